inst_mem_ctrl: RTL

Parametrised, loadable instruction memory for the S-Machine CPU fetch stage. It replaces a fixed, hard-coded program store with a RAM that:
- sweeps itself to NOP after reset;
- is programmed word-by-word over a load port;
- serves fetches with a one-cycle registered read, a stall hold and out-of-range fault reporting.

It sits between the boot/programming logic and the CPU fetch/decode stage.

---
 rtl/inst_mem_ctrl_if.sv | 38 +++
 rtl/inst_mem_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/inst_mem_ctrl_if.sv
//==============================================================================
// inst_mem_ctrl_if : load-port and fetch-port bundle for the instruction memory
// Revision: 1.0
//==============================================================================
`default_nettype none

interface inst_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_done;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic              fetch_ready;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_out;
    logic              fault;
    logic              load_err;
    logic [1:0]        state_o;

    modport master (
        output load_we, load_addr, load_data, load_done,
        output fetch_req, fetch_addr, stall,
        input  fetch_ready, inst_valid, inst_out, fault, load_err, state_o
    );

    modport slave (
        input  load_we, load_addr, load_data, load_done,
        input  fetch_req, fetch_addr, stall,
        output fetch_ready, inst_valid, inst_out, fault, load_err, state_o
    );
endinterface

`default_nettype wire

// File: rtl/inst_mem_ctrl.sv
//==============================================================================
// inst_mem_ctrl : loadable instruction RAM with NOP sweep, registered fetch,
//                 stall hold and out-of-range fault reporting
// Revision: 1.0
//==============================================================================
`default_nettype none

module inst_mem_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    inst_mem_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clear_idx;
    logic [DATA_W-1:0] r_inst_out;
    logic              r_inst_valid;
    logic              r_fault;
    logic              r_load_err;
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic              w_load_in_range;
    logic              w_fetch_in_range;
    logic              w_hold;
    logic              w_fetch_ready;
    logic              w_accept;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    // Extra top bit keeps the range compare valid when DEPTH == 2^ADDR_W.
    assign w_load_in_range  = {1'b0, bus.load_addr}  < C_DEPTH;
    assign w_fetch_in_range = {1'b0, bus.fetch_addr} < C_DEPTH;

    assign w_hold        = r_inst_valid && bus.stall;
    assign w_fetch_ready = (r_state == S_RUN) && !w_hold;
    assign w_accept      = bus.fetch_req && w_fetch_ready;

    // Single write port shared by the clear sweep and the load port.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_clear_idx;
        w_mem_wdata = NOP_WORD;
        if (r_state == S_CLEAR) begin
            w_mem_we = 1'b1;
        end else if (r_state == S_LOAD && bus.load_we && w_load_in_range) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = bus.load_addr;
            w_mem_wdata = bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CLEAR;
            r_clear_idx  <= '0;
            r_inst_out   <= NOP_WORD;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clear_idx <= r_clear_idx + ADDR_W'(1);
                    if (r_clear_idx == C_LAST_IDX) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.load_we && !w_load_in_range) begin
                        r_load_err <= 1'b1;
                    end
                    if (bus.load_done) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_inst_valid <= 1'b1;
                        if (w_fetch_in_range) begin
                            r_inst_out <= r_mem[bus.fetch_addr];
                            r_fault    <= 1'b0;
                        end else begin
                            r_inst_out <= NOP_WORD;
                            r_fault    <= 1'b1;
                        end
                    end else if (!w_hold) begin
                        r_inst_valid <= 1'b0;
                        r_fault      <= 1'b0;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign bus.fetch_ready = w_fetch_ready;
    assign bus.inst_valid  = r_inst_valid;
    assign bus.inst_out    = r_inst_out;
    assign bus.fault       = r_fault;
    assign bus.load_err    = r_load_err;
    assign bus.state_o     = r_state;

endmodule

`default_nettype wire
